// File: rtl/signed_number_32_bit_multiplier.sv
// Sequential signed 32x32->64 shift-add multiplier with start/busy/done handshake.
// Define MUL_EARLY_TERM_EN to stop iterating once the multiplier shift register is empty.
module signed_number_32_bit_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [63:0] product,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t      state_q;
    logic [63:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc_q;
    logic [5:0]  cnt_q;
    logic        neg_q;
    logic [63:0] product_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic [63:0] acc_d;

    // |-2^31| wraps to 32'h8000_0000, which is correct as an unsigned magnitude
    always_comb begin
        mag_a_d = multiplicand[31] ? (32'd0 - multiplicand) : multiplicand;
        mag_b_d = multiplier[31]   ? (32'd0 - multiplier)   : multiplier;
        acc_d   = b_q[0] ? (acc_q + a_q) : acc_q;
    end

    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= 64'd0;
            b_q       <= 32'd0;
            acc_q     <= 64'd0;
            cnt_q     <= 6'd0;
            neg_q     <= 1'b0;
            product_q <= 64'd0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= {32'd0, mag_a_d};
                        b_q     <= mag_b_d;
                        neg_q   <= multiplicand[31] ^ multiplier[31];
                        acc_q   <= 64'd0;
                        cnt_q   <= 6'd0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
`ifdef MUL_EARLY_TERM_EN
                    if (b_q == 32'd0) begin
                        state_q <= SIGN;
                    end else begin
                        acc_q <= acc_d;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                        cnt_q <= cnt_q + 6'd1;
                    end
`else
                    acc_q <= acc_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= SIGN;
                    end
`endif
                end
                SIGN: begin
                    product_q <= neg_q ? (64'd0 - acc_q) : acc_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_signed_number_32_bit_multiplier.sv
// Randomized self-checking bench for signed_number_32_bit_multiplier.
// Reference: 64-bit signed integer product; latency from operand bit-length.
module tb_signed_number_32_bit_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] multiplicand = 32'd0;
    logic [31:0] multiplier = 32'd0;
    logic [63:0] product;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    signed_number_32_bit_multiplier dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        logic [31:0] m;
        int k;
        m = b[31] ? (32'd0 - b) : b;
        k = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) k = i + 1;
        end
        return k + 2;
`else
        return 33 + 0 * int'(b[0]);
`endif
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
    endtask

    // Waits for E0, then counts edges to done; optional mid-flight re-pulse
    // and optional back-to-back launch during the done cycle.
    task automatic finish_op(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input int repulse,
                             input bit chain, input logic [31:0] ca,
                             input logic [31:0] cb);
        int n;
        logic [63:0] exp;
        exp = ref_mul(a, b);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        while (n < 40) begin
            if (n == repulse - 1) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
                start        = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (n == repulse) start = 1'b0;
            if (done) break;
        end
        check({tag, "_lat"}, 64'(n), 64'(ref_lat(b)));
        check({tag, "_prod"}, product, exp);
        if (chain) begin
            launch(ca, cb);
        end else begin
            @(posedge clk);
            #1;
            check({tag, "_donefall"}, {63'd0, done}, 64'd0);
            check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [31:0] b);
        @(negedge clk);
        launch(a, b);
        finish_op(tag, a, b, 0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit seen;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_prod", product, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("p50x3", 32'd50, 32'd3);
        check("p50x3_val", product, 64'h96);
        run("n50x3", -32'sd50, 32'd3);
        check("n50x3_val", product, 64'hFFFF_FFFF_FFFF_FF6A);
        run("p50xn3", 32'd50, -32'sd3);
        check("p50xn3_val", product, 64'hFFFF_FFFF_FFFF_FF6A);
        run("n50xn3", -32'sd50, -32'sd3);
        check("n50xn3_val", product, 64'h96);
        run("minxmin", 32'h8000_0000, 32'h8000_0000);
        check("minxmin_val", product, 64'h4000_0000_0000_0000);
        run("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000);
        check("maxxmin_val", product, 64'hC000_0000_8000_0000);
        run("zxn7", 32'd0, -32'sd7);
        check("zxn7_val", product, 64'd0);
        run("et_b0", 32'd1234, 32'd0);
        run("et_7x3", 32'd7, 32'd3);
        check("et_7x3_val", product, 64'd21);
        run("et_1xmin", 32'd1, 32'h8000_0000);
        check("et_1xmin_val", product, 64'hFFFF_FFFF_8000_0000);

        // start re-pulsed mid-flight must not disturb the operation
        @(negedge clk);
        launch(32'd12345, 32'h7000_0001);
        finish_op("repulse", 32'd12345, 32'h7000_0001, 10, 1'b0, 32'd0, 32'd0);

        // start held across the done cycle gives back-to-back operations
        @(negedge clk);
        launch(-32'sd999, 32'h4321_8765);
        finish_op("chain1", -32'sd999, 32'h4321_8765, 0, 1'b1,
                  32'h0BAD_F00D, -32'sd77777);
        finish_op("chain2", 32'h0BAD_F00D, -32'sd77777, 0, 1'b0, 32'd0, 32'd0);

        // reset mid-operation discards the result
        @(negedge clk);
        launch(32'd555, 32'h7FFF_0003);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_prod", product, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("midrst_nodone", {63'd0, seen}, 64'd0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
            run($sformatf("rnd%0d", i), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
